// File: rtl/tlb_plru_victim.sv
// Victim selection for an N-way TLB using a heap-indexed tree pseudo-LRU.
// Grants the lowest invalid way or the tree-walk victim and holds it until the fill is acked.
module tlb_plru_victim #(
    parameter int unsigned WAYS  = 8,
    parameter int unsigned IDX_W = $clog2(WAYS)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_hit_valid,
    input  logic [WAYS-1:0]  i_hit_way,
    input  logic [WAYS-1:0]  i_way_valid,
    input  logic             i_victim_req,
    output logic             o_victim_valid,
    output logic [WAYS-1:0]  o_victim_way,
    output logic [IDX_W-1:0] o_victim_idx,
    input  logic             i_fill_ack,
    output logic             o_busy,
    output logic [WAYS-1:0]  o_plru_state
);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e           r_state;
    logic [WAYS-1:0]  r_plru;
    logic [WAYS-1:0]  r_victim_way;
    logic [IDX_W-1:0] r_victim_idx;

    logic [IDX_W-1:0] w_hit_idx;
    logic             w_hit_touch;
    logic             w_fill_touch;
    logic [WAYS-1:0]  w_after_fill;
    logic [WAYS-1:0]  w_plru_next;
    logic [IDX_W-1:0] w_inv_idx;
    logic [IDX_W-1:0] w_walk_idx;
    logic [IDX_W-1:0] w_pick_idx;
    logic [WAYS-1:0]  w_pick_way;

    // Point every node on the path to way idx away from it.
    function automatic logic [WAYS-1:0] f_touch(input logic [WAYS-1:0]  s,
                                                input logic [IDX_W-1:0] idx);
        logic [WAYS-1:0] t;
        logic [IDX_W:0]  n;
        t = s;
        n = {{IDX_W{1'b0}}, 1'b1};
        for (int l = IDX_W - 1; l >= 0; l--) begin
            t[n[IDX_W-1:0]] = ~idx[l];
            n = {n[IDX_W-1:0], idx[l]};
        end
        return t;
    endfunction

    // Follow the direction bits from the root; the leaf offset is the victim index.
    function automatic logic [IDX_W-1:0] f_walk(input logic [WAYS-1:0] s);
        logic [IDX_W:0] n;
        n = {{IDX_W{1'b0}}, 1'b1};
        for (int l = 0; l < IDX_W; l++) begin
            n = {n[IDX_W-1:0], s[n[IDX_W-1:0]]};
        end
        return n[IDX_W-1:0];
    endfunction

    always_comb begin
        w_hit_idx = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (i_hit_way[i]) begin
                w_hit_idx = w_hit_idx | IDX_W'(i);
            end
        end
        w_inv_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!i_way_valid[i]) begin
                w_inv_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_hit_touch  = i_hit_valid && (i_hit_way != '0);
        w_fill_touch = (r_state == StGrant) && i_fill_ack;
        w_after_fill = w_fill_touch ? f_touch(r_plru, r_victim_idx) : r_plru;
        // Hit is applied last so it wins on nodes shared with the fill path.
        w_plru_next  = w_hit_touch ? f_touch(w_after_fill, w_hit_idx) : w_after_fill;
        w_walk_idx   = f_walk(r_plru);
        w_pick_idx   = (&i_way_valid) ? w_walk_idx : w_inv_idx;
        w_pick_way   = '0;
        w_pick_way[w_pick_idx] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_plru       <= '0;
            r_victim_way <= '0;
            r_victim_idx <= '0;
        end else if (i_flush) begin
            r_state      <= StIdle;
            r_plru       <= '0;
            r_victim_way <= '0;
            r_victim_idx <= '0;
        end else begin
            r_plru <= w_plru_next;
            case (r_state)
                StIdle: begin
                    if (i_victim_req) begin
                        r_state      <= StGrant;
                        r_victim_way <= w_pick_way;
                        r_victim_idx <= w_pick_idx;
                    end
                end
                StGrant: begin
                    if (i_fill_ack) begin
                        r_state      <= StIdle;
                        r_victim_way <= '0;
                        r_victim_idx <= '0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_busy         = (r_state == StGrant);
    assign o_victim_valid = (r_state == StGrant);
    assign o_victim_way   = r_victim_way;
    assign o_victim_idx   = r_victim_idx;
    assign o_plru_state   = r_plru;

endmodule

// File: tb/tb_tlb_plru_victim.sv
// Directed bench for tlb_plru_victim (8 ways) with hand-computed tree states and victims.
module tb_tlb_plru_victim;

    logic       clk = 1'b0;
    logic       reset, flush, hit_valid, victim_req, fill_ack;
    logic [7:0] hit_way, way_valid;
    logic       victim_valid, busy;
    logic [7:0] victim_way, plru_state;
    logic [2:0] victim_idx;

    int n_checks = 0;
    int n_errors = 0;

    tlb_plru_victim #(.WAYS(8), .IDX_W(3)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_flush        (flush),
        .i_hit_valid    (hit_valid),
        .i_hit_way      (hit_way),
        .i_way_valid    (way_valid),
        .i_victim_req   (victim_req),
        .o_victim_valid (victim_valid),
        .o_victim_way   (victim_way),
        .o_victim_idx   (victim_idx),
        .i_fill_ack     (fill_ack),
        .o_busy         (busy),
        .o_plru_state   (plru_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; flush = 0; hit_valid = 0; hit_way = 8'h00;
        victim_req = 0; fill_ack = 0; way_valid = 8'hFF;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        n_checks++; if (plru_state !== 8'h00) begin n_errors++;
            $display("FAIL reset_plru: got %h want 00", plru_state); end
        n_checks++; if (victim_valid !== 1'b0) begin n_errors++;
            $display("FAIL reset_valid: got %b want 0", victim_valid); end
        n_checks++; if (victim_way !== 8'h00) begin n_errors++;
            $display("FAIL reset_way: got %h want 00", victim_way); end
        n_checks++; if (victim_idx !== 3'd0) begin n_errors++;
            $display("FAIL reset_idx: got %0d want 0", victim_idx); end
        n_checks++; if (busy !== 1'b0) begin n_errors++;
            $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 0;
    endtask

    task automatic test_first_grant();
        do_reset();
        victim_req = 1;
        tick();
        victim_req = 0;
        n_checks++; if (victim_valid !== 1'b1) begin n_errors++;
            $display("FAIL first_valid: got %b want 1", victim_valid); end
        n_checks++; if (busy !== 1'b1) begin n_errors++;
            $display("FAIL first_busy: got %b want 1", busy); end
        n_checks++; if (victim_idx !== 3'd0) begin n_errors++;
            $display("FAIL first_idx: got %0d want 0", victim_idx); end
        n_checks++; if (victim_way !== 8'h01) begin n_errors++;
            $display("FAIL first_way: got %h want 01", victim_way); end
        n_checks++; if (plru_state !== 8'h00) begin n_errors++;
            $display("FAIL first_plru: got %h want 00", plru_state); end
        fill_ack = 1;
        tick();
        fill_ack = 0;
        n_checks++; if (victim_valid !== 1'b0) begin n_errors++;
            $display("FAIL first_fill_valid: got %b want 0", victim_valid); end
        n_checks++; if (plru_state !== 8'h16) begin n_errors++;
            $display("FAIL first_fill_plru: got %h want 16", plru_state); end
    endtask

    task automatic test_hit_walk();
        do_reset();
        hit_valid = 1; hit_way = 8'h01;
        tick();
        hit_valid = 0; hit_way = 8'h00;
        n_checks++; if (plru_state !== 8'h16) begin n_errors++;
            $display("FAIL hit0_plru: got %h want 16", plru_state); end
        victim_req = 1;
        tick();
        victim_req = 0;
        n_checks++; if (victim_idx !== 3'd4 || victim_way !== 8'h10) begin n_errors++;
            $display("FAIL walk4: got idx %0d way %h want idx 4 way 10", victim_idx, victim_way); end
        hit_valid = 1; hit_way = 8'h20;
        tick();
        hit_valid = 0; hit_way = 8'h00;
        n_checks++; if (plru_state !== 8'h1C) begin n_errors++;
            $display("FAIL hit5_plru: got %h want 1C", plru_state); end
        n_checks++; if (victim_idx !== 3'd4 || victim_valid !== 1'b1) begin n_errors++;
            $display("FAIL hold_after_hit: got idx %0d valid %b want 4 1", victim_idx, victim_valid); end
        fill_ack = 1;
        tick();
        fill_ack = 0;
        n_checks++; if (plru_state !== 8'h5C) begin n_errors++;
            $display("FAIL fill4_plru: got %h want 5C", plru_state); end
        victim_req = 1;
        tick();
        victim_req = 0;
        n_checks++; if (victim_idx !== 3'd2 || victim_way !== 8'h04) begin n_errors++;
            $display("FAIL walk2: got idx %0d way %h want idx 2 way 04", victim_idx, victim_way); end
        fill_ack = 1;
        tick();
        fill_ack = 0;
        n_checks++; if (plru_state !== 8'h7A) begin n_errors++;
            $display("FAIL fill2_plru: got %h want 7A", plru_state); end
    endtask

    task automatic test_invalid_way();
        do_reset();
        hit_valid = 1; hit_way = 8'h01;
        tick();
        hit_valid = 0; hit_way = 8'h00;
        way_valid = 8'hAF; victim_req = 1;
        tick();
        victim_req = 0; way_valid = 8'hFF;
        n_checks++; if (victim_idx !== 3'd4 || victim_way !== 8'h10) begin n_errors++;
            $display("FAIL inv_AF: got idx %0d way %h want idx 4 way 10", victim_idx, victim_way); end
        fill_ack = 1;
        tick();
        fill_ack = 0;
        way_valid = 8'hBF; victim_req = 1;
        tick();
        victim_req = 0; way_valid = 8'hFF;
        n_checks++; if (victim_idx !== 3'd6 || victim_way !== 8'h40) begin n_errors++;
            $display("FAIL inv_BF: got idx %0d way %h want idx 6 way 40", victim_idx, victim_way); end
        fill_ack = 1;
        tick();
        fill_ack = 0;
    endtask

    task automatic test_fill_and_hit();
        do_reset();
        victim_req = 1;
        tick();
        victim_req = 0;
        way_valid = 8'h00; hit_valid = 1; hit_way = 8'h80;
        tick();
        hit_valid = 0; hit_way = 8'h00;
        n_checks++; if (victim_idx !== 3'd0 || victim_way !== 8'h01 || victim_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL grant_hold: got idx %0d way %h valid %b want 0 01 1",
                     victim_idx, victim_way, victim_valid); end
        way_valid = 8'hFF;
        fill_ack = 1; hit_valid = 1; hit_way = 8'h20;
        tick();
        fill_ack = 0; hit_valid = 0; hit_way = 8'h00;
        n_checks++; if (plru_state !== 8'h1C) begin n_errors++;
            $display("FAIL fill_hit_plru: got %h want 1C", plru_state); end
        n_checks++; if (victim_valid !== 1'b0) begin n_errors++;
            $display("FAIL fill_hit_valid: got %b want 0", victim_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        victim_req = 1;
        tick();
        victim_req = 0;
        hit_valid = 1; hit_way = 8'h01;
        tick();
        hit_valid = 0; hit_way = 8'h00;
        n_checks++; if (plru_state !== 8'h16) begin n_errors++;
            $display("FAIL pre_flush_plru: got %h want 16", plru_state); end
        flush = 1;
        tick();
        flush = 0;
        n_checks++; if (victim_valid !== 1'b0 || busy !== 1'b0 || plru_state !== 8'h00) begin
            n_errors++;
            $display("FAIL flush: got valid %b busy %b plru %h want 0 0 00",
                     victim_valid, busy, plru_state); end
        fill_ack = 1;
        tick();
        fill_ack = 0;
        n_checks++; if (victim_valid !== 1'b0 || plru_state !== 8'h00) begin n_errors++;
            $display("FAIL idle_fill: got valid %b plru %h want 0 00", victim_valid, plru_state); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        hit_valid = 1; hit_way = 8'h01;
        tick();
        hit_valid = 0; hit_way = 8'h00;
        victim_req = 1;
        tick();
        victim_req = 0;
        reset = 1; fill_ack = 1;
        tick();
        reset = 0; fill_ack = 0;
        n_checks++; if (victim_valid !== 1'b0 || busy !== 1'b0 || victim_way !== 8'h00 ||
                        victim_idx !== 3'd0 || plru_state !== 8'h00) begin
            n_errors++;
            $display("FAIL mid_reset: got valid %b busy %b way %h idx %0d plru %h want all 0",
                     victim_valid, busy, victim_way, victim_idx, plru_state); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        victim_req = 1;
        tick();
        way_valid = 8'hFE;
        tick();
        tick();
        victim_req = 0; way_valid = 8'hFF;
        n_checks++; if (victim_valid !== 1'b1 || victim_idx !== 3'd0 || victim_way !== 8'h01) begin
            n_errors++;
            $display("FAIL held_req: got valid %b idx %0d way %h want 1 0 01",
                     victim_valid, victim_idx, victim_way); end
        fill_ack = 1;
        tick();
        fill_ack = 0;
        n_checks++; if (victim_valid !== 1'b0 || plru_state !== 8'h16) begin n_errors++;
            $display("FAIL b2b_fill: got valid %b plru %h want 0 16", victim_valid, plru_state); end
        victim_req = 1;
        tick();
        victim_req = 0;
        n_checks++; if (victim_valid !== 1'b1 || victim_idx !== 3'd4 || victim_way !== 8'h10) begin
            n_errors++;
            $display("FAIL b2b_grant: got valid %b idx %0d way %h want 1 4 10",
                     victim_valid, victim_idx, victim_way); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_first_grant();
        test_hit_walk();
        test_invalid_way();
        test_fill_and_hit();
        test_flush();
        test_reset_mid_grant();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
